// File: rtl/nios_core_onchip_memory_arbiter_pkg.sv
// Shared constants and types for the on-chip RAM arbiter slice.
// Optional address range checking is built with NIOS_CORE_ARB_RANGE_CHECK_EN.
package nios_core_mem_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 3750;

  localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

  typedef enum logic {
    SRC_M0 = 1'b0,
    SRC_M1 = 1'b1
  } src_e;

  // True when a zero-extended word address falls inside the implemented RAM.
  function automatic logic in_range(input logic [31:0] addr, input int depth);
    return (addr < 32'(depth));
  endfunction

endpackage

// File: rtl/nios_core_onchip_memory_arbiter_if.sv
// Avalon-MM master-side bus bundle; one instance per master feeding the arbiter.
interface nios_core_onchip_memory_arbiter_if #(
  parameter int ADDR_W = nios_core_mem_pkg::ADDR_W,
  parameter int DATA_W = nios_core_mem_pkg::DATA_W
);

  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );

endinterface

// File: rtl/nios_core_onchip_memory_arbiter_grant.sv
// Fixed-priority grant (m0 first) with a starvation counter that forces an
// m1 grant after MAX_CONSEC consecutive m0 wins while m1 waits.
module nios_core_arb_grant #(
  parameter int MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rq_0,
  input  logic rq_1,
  output logic gnt_0,
  output logic gnt_1
);

  logic [3:0] starve_cnt_r;
  logic       at_limit_s;

  assign at_limit_s = (starve_cnt_r == 4'(MAX_CONSEC));

  // Grant decision: m1 wins when alone or when m0 has used up its run.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (rq_1 && (!rq_0 || at_limit_s)) begin
      gnt_1 = 1'b1;
    end else if (rq_0) begin
      gnt_0 = 1'b1;
    end else begin
      gnt_0 = 1'b0;
      gnt_1 = 1'b0;
    end
  end

  // Starvation counter: counts m0 wins over a waiting m1, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt_r <= 4'd0;
    end else if (gnt_0 && rq_1) begin
      if (at_limit_s) begin
        starve_cnt_r <= starve_cnt_r;
      end else begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end
    end else begin
      starve_cnt_r <= 4'd0;
    end
  end

endmodule

// File: rtl/nios_core_onchip_memory_arbiter.sv
// Two-master arbiter for the single-port on-chip RAM: grant muxing and
// one-cycle read-return routing. NIOS_CORE_ARB_RANGE_CHECK_EN adds range checks.
module nios_core_onchip_memory_arbiter #(
  parameter int ADDR_W     = nios_core_mem_pkg::ADDR_W,
  parameter int DATA_W     = nios_core_mem_pkg::DATA_W,
`ifdef NIOS_CORE_ARB_RANGE_CHECK_EN
  parameter int DEPTH      = nios_core_mem_pkg::DEPTH,
`endif
  parameter int MAX_CONSEC = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  nios_core_onchip_memory_arbiter_if.slave m0,
  nios_core_onchip_memory_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W-1:0]     mem_readdata
`ifdef NIOS_CORE_ARB_RANGE_CHECK_EN
  ,
  output logic                  oor_err
`endif
);

  import nios_core_mem_pkg::*;

  localparam int BE_W = DATA_W / 8;

  logic              rq_0_s;
  logic              rq_1_s;
  logic              gnt_0_s;
  logic              gnt_1_s;
  logic              gnt_any_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [BE_W-1:0]   sel_be_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              sel_write_s;
  logic              sel_read_s;
  logic              oor_s;
  logic [DATA_W-1:0] ret_data_s;
  logic [ADDR_W-1:0] addr_hold_r;
  logic              rd_pend_r;
  src_e              rd_src_r;

  assign rq_0_s    = !reset && (m0.read || m0.write);
  assign rq_1_s    = !reset && (m1.read || m1.write);
  assign gnt_any_s = gnt_0_s || gnt_1_s;

  nios_core_arb_grant #(
    .MAX_CONSEC (MAX_CONSEC)
  ) u_grant (
    .clk   (clk),
    .reset (reset),
    .rq_0  (rq_0_s),
    .rq_1  (rq_1_s),
    .gnt_0 (gnt_0_s),
    .gnt_1 (gnt_1_s)
  );

  // Command mux; a simultaneous read+write is treated as a write.
  always_comb begin
    if (gnt_1_s) begin
      sel_addr_s  = m1.address;
      sel_be_s    = m1.byteenable;
      sel_wdata_s = m1.writedata;
      sel_write_s = m1.write;
      sel_read_s  = m1.read && !m1.write;
    end else begin
      sel_addr_s  = m0.address;
      sel_be_s    = m0.byteenable;
      sel_wdata_s = m0.writedata;
      sel_write_s = m0.write;
      sel_read_s  = m0.read && !m0.write;
    end
  end

`ifdef NIOS_CORE_ARB_RANGE_CHECK_EN
  logic rd_oor_r;

  assign oor_s      = gnt_any_s && !in_range(32'(sel_addr_s), DEPTH);
  assign ret_data_s = rd_oor_r ? DATA_W'(OOR_DATA) : mem_readdata;

  // Out-of-range reads return the marker word; errors stay sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_oor_r <= 1'b0;
      oor_err  <= 1'b0;
    end else begin
      rd_oor_r <= oor_s;
      oor_err  <= oor_err || oor_s;
    end
  end
`else
  assign oor_s      = 1'b0;
  assign ret_data_s = mem_readdata;
`endif

  // RAM side; the address is parked on its last value between accesses.
  always_comb begin
    if (reset) begin
      mem_address    = '0;
      mem_byteenable = '0;
      mem_writedata  = '0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
    end else if (gnt_any_s) begin
      mem_address    = sel_addr_s;
      mem_byteenable = sel_be_s;
      mem_writedata  = sel_wdata_s;
      mem_chipselect = !oor_s;
      mem_write      = sel_write_s && !oor_s;
    end else begin
      mem_address    = addr_hold_r;
      mem_byteenable = '0;
      mem_writedata  = '0;
      mem_chipselect = 1'b0;
      mem_write      = 1'b0;
    end
  end

  // Address park register and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_hold_r <= '0;
      rd_pend_r   <= 1'b0;
      rd_src_r    <= SRC_M0;
    end else begin
      if (gnt_any_s) begin
        addr_hold_r <= sel_addr_s;
      end else begin
        addr_hold_r <= addr_hold_r;
      end
      rd_pend_r <= gnt_any_s && sel_read_s;
      rd_src_r  <= gnt_1_s ? SRC_M1 : SRC_M0;
    end
  end

  assign m0.waitrequest   = reset || !gnt_0_s;
  assign m1.waitrequest   = reset || !gnt_1_s;
  assign m0.readdata      = ret_data_s;
  assign m1.readdata      = ret_data_s;
  assign m0.readdatavalid = !reset && rd_pend_r && (rd_src_r == SRC_M0);
  assign m1.readdatavalid = !reset && rd_pend_r && (rd_src_r == SRC_M1);

endmodule

// File: tb/tb_nios_core_onchip_memory_arbiter.sv
// Self-checking bench for the two-master on-chip RAM arbiter, with a
// behavioural RAM and a rule-level reference model of grants and read returns.
module tb_nios_core_onchip_memory_arbiter;
  import nios_core_mem_pkg::*;

  localparam int AW   = ADDR_W;
  localparam int DW   = DATA_W;
  localparam int BW   = DATA_W / 8;
  localparam int MAXC = 4;
`ifdef NIOS_CORE_ARB_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nios_core_onchip_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_bus ();
  nios_core_onchip_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_bus ();

  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
`ifdef NIOS_CORE_ARB_RANGE_CHECK_EN
  logic          oor_err;
`endif

  nios_core_onchip_memory_arbiter #(.MAX_CONSEC(MAXC)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0             (m0_bus),
    .m1             (m1_bus),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata)
`ifdef NIOS_CORE_ARB_RANGE_CHECK_EN
    ,
    .oor_err        (oor_err)
`endif
  );

  // Behavioural single-port RAM: registered q, byte-lane writes.
  logic [DW-1:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      mem_readdata <= ram[mem_address];
      if (mem_write)
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
    end
  end

  // Reference model state
  logic [DW-1:0] shadow [0:DEPTH-1];
  int            starve;
  bit            pend;
  int            pend_src;
  logic [DW-1:0] pend_data;
  logic [AW-1:0] last_addr;
  bit            lg0, lg1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_m(input int m, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    if (m == 0) begin
      m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
      m0_bus.writedata = d; m0_bus.byteenable = be;
    end else begin
      m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
      m1_bus.writedata = d; m1_bus.byteenable = be;
    end
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // One clock: check outputs at the falling edge, then advance the model.
  task automatic run_cycle();
    bit rq0, rq1, g0, g1, oor, wr, rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [BW-1:0] be;
    @(negedge clk);
    rq0 = m0_bus.read || m0_bus.write;
    rq1 = m1_bus.read || m1_bus.write;
    g0 = 1'b0; g1 = 1'b0; oor = 1'b0; wr = 1'b0; rd = 1'b0;
    a = '0; d = '0; be = '0;
    if (reset) begin
      chk("rst_wait0", m0_bus.waitrequest, 1);
      chk("rst_wait1", m1_bus.waitrequest, 1);
      chk("rst_valid0", m0_bus.readdatavalid, 0);
      chk("rst_valid1", m1_bus.readdatavalid, 0);
      chk("rst_cs", mem_chipselect, 0);
      chk("rst_we", mem_write, 0);
      chk("rst_addr", mem_address, 0);
      chk("rst_be", mem_byteenable, 0);
      chk("rst_wdata", mem_writedata, 0);
    end else begin
      g1 = rq1 && (!rq0 || starve >= MAXC);
      g0 = rq0 && !g1;
      chk("wait0", m0_bus.waitrequest, !g0);
      chk("wait1", m1_bus.waitrequest, !g1);
      chk("valid0", m0_bus.readdatavalid, pend && pend_src == 0);
      chk("valid1", m1_bus.readdatavalid, pend && pend_src == 1);
      if (pend && pend_src == 0) chk("rdata0", m0_bus.readdata, pend_data);
      if (pend && pend_src == 1) chk("rdata1", m1_bus.readdata, pend_data);
      if (g0 || g1) begin
        a  = g1 ? m1_bus.address : m0_bus.address;
        d  = g1 ? m1_bus.writedata : m0_bus.writedata;
        be = g1 ? m1_bus.byteenable : m0_bus.byteenable;
        wr = g1 ? m1_bus.write : m0_bus.write;
        rd = !wr;
        oor = RC && (int'(a) >= DEPTH);
        chk("mem_addr", mem_address, a);
        chk("mem_wdata", mem_writedata, d);
        chk("mem_be", mem_byteenable, be);
        chk("mem_cs", mem_chipselect, !oor);
        chk("mem_we", mem_write, wr && !oor);
      end else begin
        chk("idle_addr", mem_address, last_addr);
        chk("idle_cs", mem_chipselect, 0);
        chk("idle_we", mem_write, 0);
      end
    end
    @(posedge clk);
    lg0 = g0; lg1 = g1;
    if (reset) begin
      pend = 1'b0; starve = 0; last_addr = '0;
    end else begin
      pend = 1'b0;
      if (g0 || g1) begin
        last_addr = a;
        if (wr && !oor) begin
          for (int b = 0; b < BW; b++)
            if (be[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
        end else if (rd) begin
          pend = 1'b1;
          pend_src = g1 ? 1 : 0;
          pend_data = oor ? OOR_DATA : shadow[a];
        end
      end
      if (g0 && rq1) starve = (starve + 1 > MAXC) ? MAXC : starve + 1;
      else starve = 0;
    end
    #1;
  endtask

  typedef struct {
    logic r0, w0, r1, w1, ew0, ew1;
  } row_t;
  row_t rows [15];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      shadow[i] = '0;
    end
    mem_readdata = '0;
    starve = 0; pend = 1'b0; pend_src = 0; pend_data = '0; last_addr = '0;
    lg0 = 1'b0; lg1 = 1'b0;

    // Expected waitrequests for a starvation / priority walk (MAX_CONSEC = 4)
    rows[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rows[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rows[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rows[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rows[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    rows[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rows[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    rows[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rows[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    rows[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    rows[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rows[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rows[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    rows[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    rows[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Reset, with a request pending to show waitrequest is forced
    reset = 1'b1;
    idle_all();
    set_m(0, 1'b1, 1'b0, 12'd3, '0, 4'hF);
    run_cycle();
    run_cycle();
    reset = 1'b0;
    idle_all();
    run_cycle();
`ifdef NIOS_CORE_ARB_RANGE_CHECK_EN
    chk("oor_err_reset", oor_err, 0);
`endif

    // Single master write then read back
    set_m(0, 1'b0, 1'b1, 12'd5, 32'h1234_5678, 4'hF);
    run_cycle();
    set_m(0, 1'b1, 1'b0, 12'd5, '0, 4'hF);
    run_cycle();
    chk("seq_rd_valid", m0_bus.readdatavalid, 1);
    chk("seq_rd_data", m0_bus.readdata, 32'h1234_5678);
    idle_all();
    run_cycle();

    // Byte-lane masking
    set_m(0, 1'b0, 1'b1, 12'd7, 32'hFFFF_FFFF, 4'hF);
    run_cycle();
    set_m(0, 1'b0, 1'b1, 12'd7, 32'h0000_0000, 4'b0101);
    run_cycle();
    set_m(0, 1'b1, 1'b0, 12'd7, '0, 4'hF);
    run_cycle();
    chk("be_data", m0_bus.readdata, 32'hFF00_FF00);
    idle_all();
    run_cycle();

    // Table-driven priority / starvation walk
    for (int i = 0; i < 15; i++) begin
      set_m(0, rows[i].r0, rows[i].w0, 12'd1, 32'hA000_0000 + 32'(i), 4'hF);
      set_m(1, rows[i].r1, rows[i].w1, 12'd2, 32'hB000_0000 + 32'(i), 4'hF);
      #1;
      chk($sformatf("tbl%0d_wait0", i), m0_bus.waitrequest, rows[i].ew0);
      chk($sformatf("tbl%0d_wait1", i), m1_bus.waitrequest, rows[i].ew1);
      run_cycle();
    end
    idle_all();
    run_cycle();

    // Alternating single-master reads to different addresses
    for (int i = 0; i < 8; i++) begin
      idle_all();
      if (i % 2 == 0) set_m(0, 1'b1, 1'b0, 12'd1, '0, 4'hF);
      else            set_m(1, 1'b1, 1'b0, 12'd2, '0, 4'hF);
      run_cycle();
    end
    idle_all();
    run_cycle();

    // Read accepted, reset next cycle: no valid, counter cleared
    set_m(0, 1'b1, 1'b0, 12'd1, '0, 4'hF);
    set_m(1, 1'b1, 1'b0, 12'd2, '0, 4'hF);
    run_cycle();
    run_cycle();
    run_cycle();
    reset = 1'b1;
    run_cycle();
    chk("rst_starve_cnt", dut.u_grant.starve_cnt_r, 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) run_cycle();
    idle_all();
    run_cycle();

`ifdef NIOS_CORE_ARB_RANGE_CHECK_EN
    // Out-of-range read from m1
    set_m(1, 1'b1, 1'b0, 12'd3800, '0, 4'hF);
    #1;
    chk("oor_cs", mem_chipselect, 0);
    run_cycle();
    chk("oor_valid", m1_bus.readdatavalid, 1);
    chk("oor_data", m1_bus.readdata, 32'hDEAD_BEEF);
    chk("oor_err_set", oor_err, 1);
    idle_all();
    run_cycle();
`endif

    // Randomized traffic; a waiting master holds its command until granted
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        bit req, granted;
        req = (m == 0) ? (m0_bus.read || m0_bus.write) : (m1_bus.read || m1_bus.write);
        granted = (m == 0) ? lg0 : lg1;
        if (!req || granted) begin
          int kind;
          kind = $urandom_range(0, 9);
          if (kind < 3)
            set_m(m, 1'b0, 1'b0, '0, '0, '0);
          else
            set_m(m, kind < 6, kind >= 6, AW'($urandom_range(0, 15)),
                  $urandom, BW'($urandom_range(0, 15)));
        end
      end
      reset = ($urandom_range(0, 99) == 0);
      run_cycle();
    end
    reset = 1'b0;
    idle_all();
    run_cycle();
    run_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
